// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery exponentiation sequencer.
// Latency: none (definitions only).
// Backpressure: none.
package mont_pkg;

  localparam int MONT_N      = 1024;
  localparam int MONT_E_BITS = 1024;

  // Montgomery "1" operand used to leave the Montgomery domain: mont(A, 1) = A * R^-1 mod m
  localparam logic [MONT_N-1:0] MONT_ONE = MONT_N'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ_GO,
    ST_SQ_WAIT,
    ST_MUL_GO,
    ST_MUL_WAIT,
    ST_POST_GO,
    ST_POST_WAIT,
    ST_FIN
  } mont_state_t;

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Host-side request bundle and core-side operand bundle for the exponentiation sequencer.
// Latency: none (wiring only).
// Backpressure: host sees busy; core handshake is start pulse / done.
interface mont_host_if import mont_pkg::*; #(
  parameter int N      = MONT_N,
  parameter int E_BITS = MONT_E_BITS
);
  logic              start;
  logic [N-1:0]      in_xm;
  logic [N-1:0]      in_rm;
  logic [E_BITS-1:0] in_e;
  logic [N-1:0]      in_m;
  logic              busy;
  logic              done;
  logic [N-1:0]      result;

  modport master (output start, in_xm, in_rm, in_e, in_m, input busy, done, result);
  modport slave  (input start, in_xm, in_rm, in_e, in_m, output busy, done, result);
endinterface

interface mont_core_if import mont_pkg::*; #(
  parameter int N = MONT_N
);
  logic         mont_start;
  logic [N-1:0] mont_a;
  logic [N-1:0] mont_b;
  logic [N-1:0] mont_m;
  logic [N-1:0] mont_result;
  logic         mont_done;

  modport master (output mont_start, mont_a, mont_b, mont_m, input mont_result, mont_done);
  modport slave  (input mont_start, mont_a, mont_b, mont_m, output mont_result, mont_done);
endinterface

// File: rtl/mont_exp_ctrl.sv
// Constant-time square-and-multiply sequencer driving one shared Montgomery core.
// Latency: (2*E_BITS+1)*(1+k)+2 cycles from start to done, independent of the exponent.
// Backpressure: start is only sampled in IDLE; each core op waits for mont_done.
module mont_exp_ctrl import mont_pkg::*; #(
  parameter int N      = MONT_N,
  parameter int E_BITS = MONT_E_BITS
) (
  input  logic         clk,
  input  logic         reset,
  mont_host_if.slave   host,
  mont_core_if.master  core
);

  localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(E_BITS - 1);

  mont_state_t       r_state;
  mont_state_t       w_next;
  logic [N-1:0]      r_a;
  logic [N-1:0]      r_xm;
  logic [N-1:0]      r_m;
  logic [N-1:0]      r_result;
  logic [E_BITS-1:0] r_e;
  logic [IW-1:0]     r_i;
  logic              r_done;
  logic              w_accept;
  logic              w_mont_start;
  logic [N-1:0]      w_b;

  assign w_accept = (r_state == ST_IDLE) && host.start;

  // State register; reset clears the FSM (and thus mont_start) asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and core-facing controls; mont_done only matters in the *_WAIT states
  always_comb begin
    w_next       = r_state;
    w_mont_start = 1'b0;
    w_b          = r_a;
    case (r_state)
      ST_IDLE:      if (host.start) w_next = ST_SQ_GO;
      ST_SQ_GO:     begin w_next = ST_SQ_WAIT; w_mont_start = 1'b1; end
      ST_SQ_WAIT:   if (core.mont_done) w_next = ST_MUL_GO;
      ST_MUL_GO:    begin w_next = ST_MUL_WAIT; w_mont_start = 1'b1; w_b = r_xm; end
      ST_MUL_WAIT:  begin
                      w_b = r_xm;
                      if (core.mont_done) w_next = (r_i == '0) ? ST_POST_GO : ST_SQ_GO;
                    end
      ST_POST_GO:   begin w_next = ST_POST_WAIT; w_mont_start = 1'b1; w_b = N'(MONT_ONE); end
      ST_POST_WAIT: begin
                      w_b = N'(MONT_ONE);
                      if (core.mont_done) w_next = ST_FIN;
                    end
      ST_FIN:       w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Operand latch, accumulator update, bit index and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_xm     <= '0;
      r_m      <= '0;
      r_e      <= '0;
      r_i      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIN);
      if (w_accept) begin
        r_xm <= host.in_xm;
        r_e  <= host.in_e;
        r_m  <= host.in_m;
        r_a  <= host.in_rm;
        r_i  <= I_TOP;
      end
      if (core.mont_done) begin
        case (r_state)
          ST_SQ_WAIT: r_a <= core.mont_result;
          ST_MUL_WAIT: begin
            // multiply is always issued; its product is kept only for a set bit
            if (r_e[r_i]) r_a <= core.mont_result;
            if (r_i != '0) r_i <= r_i - 1'b1;
          end
          ST_POST_WAIT: begin
            r_a      <= core.mont_result;
            r_result <= core.mont_result;
          end
          default: ;
        endcase
      end
    end
  end

  assign core.mont_start = w_mont_start;
  assign core.mont_a     = r_a;
  assign core.mont_b     = w_b;
  assign core.mont_m     = r_m;

  // busy spans the whole run including the done cycle after FIN
  assign host.busy   = (r_state != ST_IDLE) || r_done;
  assign host.done   = r_done;
  assign host.result = r_result;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with a behavioural Montgomery core (k = 3).
// Latency: directed runs of 70 cycles each with N = 8, E_BITS = 8.
// Backpressure: core model answers every mont_start after a fixed delay.
module tb_mont_exp_ctrl;
  import mont_pkg::*;

  localparam int N  = 8;
  localparam int EB = 8;
  localparam int K  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mont_host_if #(.N(N), .E_BITS(EB)) host ();
  mont_core_if #(.N(N))              core ();

  mont_exp_ctrl #(.N(N), .E_BITS(EB)) dut (
    .clk   (clk),
    .reset (reset),
    .host  (host),
    .core  (core)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural core: result = a*b*R^-1 mod m, R = 2^N
  function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    for (int j = 0; j < N; j++) begin
      if (p[0]) p = p + longint'(m);
      p = p >> 1;
    end
    if (p >= longint'(m)) p = p - longint'(m);
    return p[N-1:0];
  endfunction

  // Core model: done sampled high k cycles after the start cycle; optionally held as a level
  bit lvl_mode   = 1'b0;
  int cnt        = 0;
  bit pend       = 1'b0;
  int proto_viol = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core.mont_done   <= 1'b0;
      core.mont_result <= '0;
      cnt              <= 0;
      pend             <= 1'b0;
    end else if (core.mont_start) begin
      if (pend) proto_viol <= proto_viol + 1;
      pend             <= 1'b1;
      cnt              <= K - 1;
      core.mont_done   <= 1'b0;
      core.mont_result <= mont_ref(core.mont_a, core.mont_b, core.mont_m);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core.mont_done <= 1'b1;
        pend           <= 1'b0;
      end
    end else if (!lvl_mode) begin
      core.mont_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [N-1:0] m;
    logic [N-1:0] xm;
    logic [N-1:0] rm;
    logic [EB-1:0] e;
    int           restart_at;
    bit           lvl;
    logic [N-1:0] exp_res;
    int           exp_lat;
    int           exp_pulses;
  } vec_t;

  vec_t vecs[5];

  // Launch one run and watch it cycle by cycle; cycle 1 is the first cycle after the start edge
  task automatic run_vec(input vec_t v, output int lat, output int pulses,
                         output logic [N-1:0] res, output logic busy1);
    lat    = -1;
    pulses = 0;
    res    = '0;
    busy1  = 1'b0;
    lvl_mode    = v.lvl;
    host.in_m   = v.m;
    host.in_xm  = v.xm;
    host.in_rm  = v.rm;
    host.in_e   = v.e;
    host.start  = 1'b1;
    @(posedge clk); #1;
    host.start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc == 1) busy1 = host.busy;
      if (core.mont_start) pulses++;
      if (host.done) begin
        lat = cyc;
        res = host.result;
        break;
      end
      if (v.restart_at != 0 && cyc == v.restart_at) begin
        host.start = 1'b1;
        host.in_e  = '1;
        host.in_xm = 8'd1;
        host.in_m  = 8'd7;
        host.in_rm = 8'd4;
      end else begin
        host.start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_and_check(input vec_t v);
    int           lat;
    int           pulses;
    logic [N-1:0] res;
    logic         busy1;
    run_vec(v, lat, pulses, res, busy1);
    chk({v.name, " result"},  res, v.exp_res);
    chk({v.name, " latency"}, lat, v.exp_lat);
    chk({v.name, " pulses"},  pulses, v.exp_pulses);
    chk({v.name, " busy_c1"}, busy1, 1);
    @(posedge clk); #1;
    chk({v.name, " done_fall"}, host.done, 0);
    chk({v.name, " busy_fall"}, host.busy, 0);
    chk({v.name, " result_held"}, host.result, v.exp_res);
    lvl_mode = 1'b0;
  endtask

  initial begin
    // R = 256: R mod 13 = 9, 2R mod 13 = 5; R mod 7 = 4, 5R mod 7 = 6, 3R mod 7 = 5
    vecs[0] = '{"m13_x2_e5",   8'd13, 8'd5, 8'd9, 8'h05, 0,  1'b0, 8'd6, 70, 17};
    vecs[1] = '{"m7_x5_e0",    8'd7,  8'd6, 8'd4, 8'h00, 0,  1'b0, 8'd1, 70, 17};
    vecs[2] = '{"m13_x2_eFF",  8'd13, 8'd5, 8'd9, 8'hFF, 0,  1'b0, 8'd8, 70, 17};
    vecs[3] = '{"restart_c10", 8'd13, 8'd5, 8'd9, 8'h05, 10, 1'b0, 8'd6, 70, 17};
    vecs[4] = '{"level_done",  8'd13, 8'd5, 8'd9, 8'h05, 0,  1'b1, 8'd6, 70, 17};

    host.start = 1'b0;
    host.in_m  = '0;
    host.in_xm = '0;
    host.in_rm = '0;
    host.in_e  = '0;

    #1;
    chk("rst busy",       host.busy, 0);
    chk("rst done",       host.done, 0);
    chk("rst result",     host.result, 0);
    chk("rst mont_start", core.mont_start, 0);
    chk("rst mont_a",     core.mont_a, 0);
    chk("rst mont_b",     core.mont_b, 0);
    chk("rst mont_m",     core.mont_m, 0);

    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) apply_and_check(vecs[v]);

    // Reset in cycle 30 of a run: everything drops in the same cycle
    host.in_m  = 8'd13;
    host.in_xm = 8'd5;
    host.in_rm = 8'd9;
    host.in_e  = 8'h05;
    host.start = 1'b1;
    @(posedge clk); #1;
    host.start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("pre_rst busy", host.busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst busy",       host.busy, 0);
    chk("mid_rst done",       host.done, 0);
    chk("mid_rst result",     host.result, 0);
    chk("mid_rst mont_start", core.mont_start, 0);
    chk("mid_rst mont_a",     core.mont_a, 0);
    chk("mid_rst mont_b",     core.mont_b, 0);
    chk("mid_rst mont_m",     core.mont_m, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    begin
      vec_t after_rst;
      after_rst = '{"after_rst_m7_x3_e6", 8'd7, 8'd5, 8'd4, 8'h06, 0, 1'b0, 8'd1, 70, 17};
      apply_and_check(after_rst);
    end

    chk("core double start", proto_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
